vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator; successor to `vga_sync`, which is fixed to one mode. Produces horizontal/vertical sync, pixel coordinates, display enable, a pixel clock-enable and line/frame start strobes from a single system clock. Any mode's porch/sync/polarity values are set by parameters, and the pixel rate by a clock-enable divider instead of a separate clock. It sits between the board clock and the pixel/pattern generators in the VGA path.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, h_sync active level (0 = active-low)
- `V_POL`, 0, v_sync active level
- `PIX_DIV`, 1, clk_in cycles per pixel (≥1)
- `CNT_W`, 10, counter width; must hold max(H_TOTAL, V_TOTAL)-1

Ports:
- `clk_in` input 1: system clock, all logic on rising edge
- `reset` input 1: asynchronous, active-low reset
- `enable` input 1: run timing; low freezes raster
- `h_sync` output 1: horizontal sync at `H_POL` level when active
- `v_sync` output 1: vertical sync at `V_POL` level when active
- `h_count` output CNT_W: current pixel column
- `v_count` output CNT_W: current line
- `display_en` output 1: high when (h_count, v_count) is in the visible area
- `pix_en` output 1: one-cycle pulse; coordinates changed this cycle
- `line_start` output 1: one-cycle pulse with pix_en when h_count becomes 0
- `frame_start` output 1: one-cycle pulse with pix_en when h_count and v_count both become 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider `div` counts 0..PIX_DIV-1 while enable=1. Internal tick = enable && div==PIX_DIV-1.
- On a tick, h_count increments and wraps from H_TOTAL-1 to 0. On that wrap, v_count increments and wraps from V_TOTAL-1 to 0.
- h_sync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; v_sync likewise on v. Otherwise each sync is at its inactive level (~POL).
- display_en = (h < H_ACTIVE) && (v < V_ACTIVE).
- All outputs are registered and decoded from the next-state counts, so syncs, display_en and strobes are aligned with h_count/v_count in the same cycle.
- enable=0:
  - counters, syncs and display_en hold;
  - div clears to 0;
  - pix_en, line_start and frame_start are 0.
- Arithmetic is unsigned CNT_W. Totals are compile-time constants. Elaboration fails if CNT_W is insufficient or PIX_DIV<1.

## Timing
- Reset values:
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1;
  - h_sync = ~H_POL, v_sync = ~V_POL;
  - display_en, pix_en, line_start, frame_start = 0;
  - div = 0.
- With enable=1 from reset release, the first tick comes PIX_DIV cycles after release. That edge moves to (0,0) with display_en=1 and pix_en, line_start, frame_start all =1.
- A tick occurs every PIX_DIV cycles while enabled. With PIX_DIV=1, pix_en is constantly 1.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronous). No partial strobe is emitted.
- enable deasserted on a tick cycle: that tick does not occur. Re-enabling resumes from the held position after PIX_DIV cycles.

## Structure
- Package `vga_timing_pkg`: mode constants for 640x480@60 (defaults above) and 800x600@60, plus a `total()` helper function.
- Sub-module `pix_clk_div`: parametrised clock-enable divider (PIX_DIV, enable, reset) producing the tick.
- Top: counters, sync/blank decode, output registers.

## Test plan
Small mode for the bench: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), PIX_DIV=2, polarities 0.
- Reset release, enable=1 -> first pix_en 2 cycles later. On it, h=0, v=0, display_en=1, line_start=1, frame_start=1.
- Free-run one frame -> pix_en every 2 cycles; frame_start period 224 cycles. h_sync low exactly for h=10..12; v_sync low for v=5..6; display_en only for h<8, v<4.
- Line wrap: h=13 -> next tick h=0, v+1, line_start=1, frame_start=0. At v=7, the wrap gives v=0 and frame_start=1.
- enable=0 for 7 cycles at h=5 -> all outputs hold, no strobes. On re-enable, h=6 after 2 cycles.
- Reset asserted at h=9, v=2 -> outputs return to reset values in the same cycle; restart per the first scenario.
- H_POL=1, V_POL=1, PIX_DIV=1 -> syncs high only in their windows; pix_en stuck at 1; frame_start period 112 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Mode constants for the VGA raster timing generator and a helper that sums
// the four segments of one axis (active, front porch, sync, back porch).
// No ports; imported by the timing generator top.
package vga_timing_pkg;

   typedef struct packed {
      logic [15:0] active;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } axis_t;

   // 640x480 @ 60 Hz, 25.175 MHz pixel rate, both syncs active-low
   localparam axis_t VGA640_H   = '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48};
   localparam axis_t VGA640_V   = '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33};
   localparam bit    VGA640_POL = 1'b0;

   // 800x600 @ 60 Hz, 40 MHz pixel rate, both syncs active-high
   localparam axis_t VGA800_H   = '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88};
   localparam axis_t VGA800_V   = '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23};
   localparam bit    VGA800_POL = 1'b1;

   function automatic int unsigned total(input int unsigned active,
                                         input int unsigned fp,
                                         input int unsigned sync,
                                         input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_if
// Raster bus between the timing generator and the pixel/pattern generators.
//   enable      : run timing (driven by the consumer side)
//   h_sync      : horizontal sync at the configured polarity
//   v_sync      : vertical sync at the configured polarity
//   h_count     : current pixel column
//   v_count     : current line
//   display_en  : coordinates are inside the visible area
//   pix_en      : coordinates changed this cycle
//   line_start  : h_count became 0 this cycle
//   frame_start : h_count and v_count both became 0 this cycle
interface vga_timing_if #(
   parameter int unsigned CNT_W = 10
);
   logic             enable;
   logic             h_sync;
   logic             v_sync;
   logic [CNT_W-1:0] h_count;
   logic [CNT_W-1:0] v_count;
   logic             display_en;
   logic             pix_en;
   logic             line_start;
   logic             frame_start;

   modport master (
      input  enable,
      output h_sync, v_sync, h_count, v_count,
      output display_en, pix_en, line_start, frame_start
   );

   modport slave (
      output enable,
      input  h_sync, v_sync, h_count, v_count,
      input  display_en, pix_en, line_start, frame_start
   );
endinterface

// File: rtl/pix_clk_div.sv
// pix_clk_div
// Pixel clock-enable divider: asserts tick once every PIX_DIV clk_in cycles
// while enable is high. Dropping enable restarts the count so the first tick
// after re-enable comes a full PIX_DIV cycles later.
//   clk_in : system clock
//   reset  : asynchronous active-low reset
//   enable : run the divider
//   tick   : combinational pixel-advance strobe
module pix_clk_div #(
   parameter int unsigned PIX_DIV = 1
) (
   input  logic clk_in,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] RELOAD = DIV_W'(PIX_DIV - 1);

   if (PIX_DIV < 1) begin : g_bad_div
      $fatal(1, "pix_clk_div: PIX_DIV must be at least 1");
   end

   // Down-counter of cycles remaining until the next tick; tick on zero.
   logic [DIV_W-1:0] rem_q;
   logic [DIV_W-1:0] rem_d;

   always_comb begin
      tick  = enable && (rem_q == '0);
      rem_d = rem_q;
      if (!enable || tick) begin
         rem_d = RELOAD;
      end else begin
         rem_d = rem_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         rem_q <= RELOAD;
      end else begin
         rem_q <= rem_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. Pixel rate comes from a
// clock-enable divider on clk_in. All outputs are registered and decoded
// from the next-state counts, so syncs, display_en and strobes line up with
// h_count/v_count in the same cycle.
//   clk_in : system clock
//   reset  : asynchronous active-low reset
//   bus    : raster bus (enable in; syncs, counts, enables, strobes out)
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned PIX_DIV  = 1,
   parameter int unsigned CNT_W    = 10
) (
   input  logic          clk_in,
   input  logic          reset,
   vga_timing_if.master  bus
);

   localparam int unsigned H_TOTAL   = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL   = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;  // exclusive
   localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;  // exclusive
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   if ((((H_TOTAL - 1) >> CNT_W) != 0) || (((V_TOTAL - 1) >> CNT_W) != 0)) begin : g_bad_cnt_w
      $fatal(1, "vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
   end

   logic tick;

   pix_clk_div #(
      .PIX_DIV (PIX_DIV)
   ) u_pix_clk_div (
      .clk_in (clk_in),
      .reset  (reset),
      .enable (bus.enable),
      .tick   (tick)
   );

   logic [CNT_W-1:0] h_count_q, h_count_d;
   logic [CNT_W-1:0] v_count_q, v_count_d;
   logic             h_sync_q, h_sync_d;
   logic             v_sync_q, v_sync_d;
   logic             display_en_q, display_en_d;
   logic             pix_en_q, pix_en_d;
   logic             line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;
   logic [31:0]      h_ext;
   logic [31:0]      v_ext;

   always_comb begin
      h_count_d = h_count_q;
      v_count_d = v_count_q;
      if (tick) begin
         if (h_count_q == H_LAST) begin
            h_count_d = '0;
            v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + CNT_W'(1);
         end else begin
            h_count_d = h_count_q + CNT_W'(1);
         end
      end

      // Decode against the next counts so every output moves with them.
      // Widen first: sync window ends may sit one past the counter range.
      h_ext = 32'(h_count_d);
      v_ext = 32'(v_count_d);

      h_sync_d      = ((h_ext >= H_SYNC_LO) && (h_ext < H_SYNC_HI)) ? H_POL : ~H_POL;
      v_sync_d      = ((v_ext >= V_SYNC_LO) && (v_ext < V_SYNC_HI)) ? V_POL : ~V_POL;
      display_en_d  = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
      pix_en_d      = tick;
      line_start_d  = tick && (h_count_d == '0);
      frame_start_d = line_start_d && (v_count_d == '0);
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         h_count_q     <= H_LAST;
         v_count_q     <= V_LAST;
         h_sync_q      <= ~H_POL;
         v_sync_q      <= ~V_POL;
         display_en_q  <= 1'b0;
         pix_en_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_count_q     <= h_count_d;
         v_count_q     <= v_count_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         display_en_q  <= display_en_d;
         pix_en_q      <= pix_en_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.h_count     = h_count_q;
   assign bus.v_count     = v_count_q;
   assign bus.h_sync      = h_sync_q;
   assign bus.v_sync      = v_sync_q;
   assign bus.display_en  = display_en_q;
   assign bus.pix_en      = pix_en_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Bench for vga_timing_gen in a small mode: H 8/2/3/1 (14), V 4/1/2/1 (8).
// dut_a: PIX_DIV=2, active-low syncs. dut_b: PIX_DIV=1, active-high syncs.
module tb_vga_timing_gen;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   logic en      = 1'b0;

   always #5 clk_sys = ~clk_sys;

   vga_timing_if #(.CNT_W(10)) bus_a ();
   vga_timing_if #(.CNT_W(10)) bus_b ();

   assign bus_a.enable = en;
   assign bus_b.enable = en;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(2), .CNT_W(10)
   ) dut_a (
      .clk_in (clk_sys),
      .reset  (rst_n),
      .bus    (bus_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .CNT_W(10)
   ) dut_b (
      .clk_in (clk_sys),
      .reset  (rst_n),
      .bus    (bus_b)
   );

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       de;
      logic       pe;
      logic       ls;
      logic       fs;
   } obs_t;

   typedef struct {
      int   n;
      obs_t exp;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int last_fs;

   function automatic obs_t mk(input int h, input int v, input bit hs, input bit vs,
                               input bit de, input bit pe, input bit ls, input bit fs);
      obs_t o;
      o.h = 10'(h); o.v = 10'(v);
      o.hs = hs; o.vs = vs; o.de = de; o.pe = pe; o.ls = ls; o.fs = fs;
      return o;
   endfunction

   // Expected outputs for raster position p (pixel ticks since the first one).
   function automatic obs_t model(input int p, input bit pe, input bit hpol, input bit vpol);
      int h;
      int v;
      if (p < 0) return mk(13, 7, ~hpol, ~vpol, 1'b0, 1'b0, 1'b0, 1'b0);
      h = p % 14;
      v = (p / 14) % 8;
      return mk(h, v,
                (h >= 10 && h <= 12) ? hpol : ~hpol,
                (v >= 5 && v <= 6) ? vpol : ~vpol,
                (h < 8) && (v < 4),
                pe, pe && (h == 0), pe && (h == 0) && (v == 0));
   endfunction

   function automatic obs_t get_a();
      return mk(int'(bus_a.h_count), int'(bus_a.v_count), bus_a.h_sync, bus_a.v_sync,
                bus_a.display_en, bus_a.pix_en, bus_a.line_start, bus_a.frame_start);
   endfunction

   function automatic obs_t get_b();
      return mk(int'(bus_b.h_count), int'(bus_b.v_count), bus_b.h_sync, bus_b.v_sync,
                bus_b.display_en, bus_b.pix_en, bus_b.line_start, bus_b.frame_start);
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got h=%0d v=%0d hs=%0b vs=%0b de=%0b pe=%0b ls=%0b fs=%0b, want h=%0d v=%0d hs=%0b vs=%0b de=%0b pe=%0b ls=%0b fs=%0b",
                  name, cyc, act.h, act.v, act.hs, act.vs, act.de, act.pe, act.ls, act.fs,
                  exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.pe, exp.ls, exp.fs);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
      cyc++;
   endtask

   // Hold reset over two edges, then release with enable high; cyc counts
   // edges after release.
   task automatic do_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      step();
      step();
      en    = 1'b1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   vec_t tbl[18];

   initial begin
      //            n     h   v  hs vs de pe ls fs
      tbl[0]  = '{0,   mk(13, 7, 1, 1, 0, 0, 0, 0)};
      tbl[1]  = '{1,   mk(13, 7, 1, 1, 0, 0, 0, 0)};
      tbl[2]  = '{2,   mk(0,  0, 1, 1, 1, 1, 1, 1)};
      tbl[3]  = '{3,   mk(0,  0, 1, 1, 1, 0, 0, 0)};
      tbl[4]  = '{4,   mk(1,  0, 1, 1, 1, 1, 0, 0)};
      tbl[5]  = '{18,  mk(8,  0, 1, 1, 0, 1, 0, 0)};
      tbl[6]  = '{22,  mk(10, 0, 0, 1, 0, 1, 0, 0)};
      tbl[7]  = '{26,  mk(12, 0, 0, 1, 0, 1, 0, 0)};
      tbl[8]  = '{28,  mk(13, 0, 1, 1, 0, 1, 0, 0)};
      tbl[9]  = '{30,  mk(0,  1, 1, 1, 1, 1, 1, 0)};
      tbl[10] = '{120, mk(3,  4, 1, 1, 0, 1, 0, 0)};
      tbl[11] = '{142, mk(0,  5, 1, 0, 0, 1, 1, 0)};
      tbl[12] = '{192, mk(11, 6, 0, 0, 0, 1, 0, 0)};
      tbl[13] = '{198, mk(0,  7, 1, 1, 0, 1, 1, 0)};
      tbl[14] = '{224, mk(13, 7, 1, 1, 0, 1, 0, 0)};
      tbl[15] = '{225, mk(13, 7, 1, 1, 0, 0, 0, 0)};
      tbl[16] = '{226, mk(0,  0, 1, 1, 1, 1, 1, 1)};
      tbl[17] = '{227, mk(0,  0, 1, 1, 1, 0, 0, 0)};

      // Directed vectors through the first frame of dut_a.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         while (cyc < tbl[i].n) step();
         check("vec_a", get_a(), tbl[i].exp);
      end

      // Second frame free-run: every cycle against the raster position.
      last_fs = 226;
      while (cyc < 460) begin
         step();
         check("run_a", get_a(), model(cyc / 2 - 1, (cyc % 2) == 0, 1'b0, 1'b0));
         if (bus_a.frame_start) begin
            check_int("fs_period_a", cyc - last_fs, 224);
            last_fs = cyc;
         end
      end
      check_int("fs_seen_a", last_fs, 450);

      // Enable dropped for 7 cycles at h=5, then dropped on a tick cycle.
      do_reset();
      while (cyc < 12) step();
      check("hold_pre", get_a(), mk(5, 0, 1, 1, 1, 1, 0, 0));
      en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         check("hold", get_a(), mk(5, 0, 1, 1, 1, 0, 0, 0));
      end
      en = 1'b1;
      step();
      check("resume_wait", get_a(), mk(5, 0, 1, 1, 1, 0, 0, 0));
      step();
      check("resume_tick", get_a(), mk(6, 0, 1, 1, 1, 1, 0, 0));
      step();
      check("pre_drop", get_a(), mk(6, 0, 1, 1, 1, 0, 0, 0));
      en = 1'b0;
      step();
      check("drop_on_tick", get_a(), mk(6, 0, 1, 1, 1, 0, 0, 0));
      en = 1'b1;
      step();
      check("redrop_wait", get_a(), mk(6, 0, 1, 1, 1, 0, 0, 0));
      step();
      check("redrop_tick", get_a(), mk(7, 0, 1, 1, 1, 1, 0, 0));

      // Asynchronous reset mid-frame at h=9, v=2.
      do_reset();
      while (cyc < 76) step();
      check("pre_reset", get_a(), mk(9, 2, 1, 1, 0, 1, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", get_a(), mk(13, 7, 1, 1, 0, 0, 0, 0));
      step();
      check("reset_held", get_a(), mk(13, 7, 1, 1, 0, 0, 0, 0));
      rst_n = 1'b1;
      cyc   = 0;
      step();
      check("restart_1", get_a(), mk(13, 7, 1, 1, 0, 0, 0, 0));
      step();
      check("restart_2", get_a(), mk(0, 0, 1, 1, 1, 1, 1, 1));

      // dut_b: active-high syncs, one pixel per clock.
      do_reset();
      check("reset_b", get_b(), model(-1, 1'b0, 1'b1, 1'b1));
      last_fs = -1;
      while (cyc < 240) begin
         step();
         check("run_b", get_b(), model(cyc - 1, 1'b1, 1'b1, 1'b1));
         if (bus_b.frame_start) begin
            if (last_fs >= 0) check_int("fs_period_b", cyc - last_fs, 112);
            last_fs = cyc;
         end
      end
      check_int("fs_seen_b", last_fs, 225);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
